ov_reg_seq: RTL and testbench
=============================

Name: ov_reg_seq

Overview:
- Camera register-init sequencer, directly upstream of the OV-sensor IIC/SCCB master in the ov_inf path.
- Walks an external synchronous table of 16-bit entries and issues one register-write transaction per entry to the IIC master.
- Also supports timed delay entries, retry on NACK, and done/error status for the top-level bring-up logic.

Parameters:
- DEV_ID, 8'h42, 8-bit write slave address sent with every transaction (bit0 = 0).
- TBL_AW, 8, table address width; the table holds up to 2^TBL_AW entries.
- MAX_RETRY, 3, re-issues allowed per entry after a NACK before reporting an error (0..15).
- US_PER_MS, 1000, number of pluse_us pulses per millisecond of delay.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pluse_us  in  1  one-cycle pulse every 1 us (one pulse every cycle in simulation).
- start  in  1  one-cycle pulse; begins the sequence from entry 0.
- tbl_addr  out  TBL_AW  table read address.
- tbl_data  in  16  table entry: [15:8] register, [7:0] value; valid 1 cycle after tbl_addr changes.
- wr_req  out  1  write request to the IIC master.
- wr_dev  out  8  slave address (= DEV_ID).
- wr_reg  out  8  register address.
- wr_dat  out  8  register data.
- iic_done  in  1  one-cycle pulse; the IIC transaction has finished.
- iic_nack  in  1  sampled with iic_done; 1 = slave NACKed.
- busy  out  1  sequence in progress.
- done  out  1  level; sequence completed without error.
- err  out  1  level; retries exhausted on an entry.
- err_idx  out  TBL_AW  index of the failing entry.

Behaviour:
- Reset values: tbl_addr=0, wr_req=0, wr_reg=0, wr_dat=0, busy=0, done=0, err=0, err_idx=0. wr_dev is constant DEV_ID.
- FSM states: IDLE, FETCH, DECODE, WRITE, DELAY, NEXT, DONE, ERR.
- IDLE: on start, tbl_addr<=0, retry counter<=0, busy<=1, done<=0, err<=0, go to FETCH.
- start is ignored in FETCH..NEXT. In DONE or ERR, start restarts exactly as from IDLE.
- FETCH: wait one cycle for the table read, then DECODE.
- DECODE:
  - entry 16'hFFFF → end marker → DONE.
  - [15:8]==8'hFF, any other value → delay entry of [7:0] ms → DELAY; a value of 0 goes straight to NEXT.
  - any other entry: latch wr_reg/wr_dat, assert wr_req → WRITE.
- WRITE:
  - wr_req, wr_reg and wr_dat are held stable until iic_done is seen.
  - wr_req deasserts on the cycle after iic_done.
  - iic_done with iic_nack=0 → NEXT, retry counter cleared.
  - iic_done with iic_nack=1 and retry < MAX_RETRY → retry+1; wr_req deasserts for exactly 1 cycle, then reasserts with the same fields.
  - iic_done with iic_nack=1 and retry == MAX_RETRY → err_idx<=tbl_addr → ERR.
- DELAY:
  - A 10-bit us counter counts pluse_us from 0 to US_PER_MS-1 and then wraps; each wrap decrements an 8-bit ms counter.
  - When the ms counter reaches 0 → NEXT.
  - Delay N ms elapses after N*US_PER_MS pulses (±1 pulse of phase).
- NEXT:
  - If tbl_addr == 2^TBL_AW-1 → DONE; no wrap-around.
  - Otherwise tbl_addr+1 → FETCH.
- DONE: busy=0, done=1, held until start or rst.
- ERR: busy=0, err=1, err_idx held, held until start or rst.
- iic_done arriving outside WRITE is ignored.
- Reset mid-transaction: wr_req drops on the next edge; the IIC master must abort or finish on its own.
- Throughput: one entry per IIC transaction plus 3 cycles (FETCH, DECODE, NEXT).

Optional Feature:
- Macro: OV_SEQ_READBACK_EN.
- Defined:
  - Adds ports rd_req out 1, rd_dat in 8, and mismatch flag out 1.
  - After each successful write, a READ state asserts rd_req with wr_reg held until iic_done.
  - rd_dat != wr_dat, or a NACK, counts as a failure and consumes one retry; the retry re-does the write.
  - mismatch=1 in ERR if the final failure was a data compare.
- Undefined: no readback ports or states; the sequence moves from WRITE directly to NEXT.

Test Plan:
- Table {1280, 1100, FFFF}, iic_done 20 cycles after each req, nack=0 → two writes (reg 12/dat 80, reg 11/dat 00), done=1, busy=0, err=0.
- Table {FF05, 3A04, FFFF}, pluse_us every cycle → wr_req for reg 3A asserted ≥5000 cycles after the delay entry decodes, then done=1.
- Entry 1280, MAX_RETRY=3, iic_nack=1 on every done → exactly 4 wr_req assertions, each followed by a 1-cycle gap, then err=1, err_idx=0.
- Entry 0 NACKs twice then ACKs → 3 requests, sequence continues, done=1, err=0.
- TBL_AW=2, table without an end marker → 4 writes, done=1, tbl_addr stays 3.
- Assert rst during WRITE, then start → wr_req=0 the cycle after rst, sequence restarts at tbl_addr=0; start pulses sent while busy produce no effect.

Source files
------------

// File: rtl/ov_reg_seq.sv
// ov_reg_seq: camera register-init sequencer feeding the SCCB master (optional write readback: OV_SEQ_READBACK_EN)
module ov_reg_seq #(
  parameter logic [7:0] DEV_ID    = 8'h42,
  parameter int         TBL_AW    = 8,
  parameter int         MAX_RETRY = 3,
  parameter int         US_PER_MS = 1000
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_us,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              wr_req,
  output logic [7:0]        wr_dev,
  output logic [7:0]        wr_reg,
  output logic [7:0]        wr_dat,
  input  logic              iic_done,
  input  logic              iic_nack,
`ifdef OV_SEQ_READBACK_EN
  output logic              rd_req,
  input  logic [7:0]        rd_dat,
  output logic              mismatch,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TBL_AW-1:0] err_idx
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, WRITE, DELAY, NEXT, DONE, ERR
`ifdef OV_SEQ_READBACK_EN
    , READ
`endif
  } state_t;
  localparam logic [3:0] MAX_R  = 4'(MAX_RETRY);
  localparam logic [9:0] US_TOP = 10'(US_PER_MS - 1);
  state_t state, nxt;
  logic [3:0] retry;
  logic [9:0] us_cnt;
  logic [7:0] ms_cnt;
  logic is_end, is_dly, last, wr_fin, ms_end;
  assign wr_dev = DEV_ID;
  assign is_end = tbl_data == 16'hFFFF;
  assign is_dly = tbl_data[15:8] == 8'hFF;
  assign last   = &tbl_addr;
  assign wr_fin = wr_req && iic_done;
  assign ms_end = pluse_us && us_cnt == US_TOP && ms_cnt == 8'd1;
`ifdef OV_SEQ_READBACK_EN
  logic rd_fin, rd_ok;
  assign rd_fin = rd_req && iic_done;
  assign rd_ok  = !iic_nack && rd_dat == wr_dat;
  localparam state_t WR_OK = READ;
`else
  localparam state_t WR_OK = NEXT;
`endif
  // state register
  always_ff @(posedge clk_sys) state <= rst ? IDLE : nxt;
  // next-state: a NACK either re-enters WRITE for a retry or ends in ERR
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? FETCH : state;
      FETCH:           nxt = DECODE;
      DECODE:          nxt = is_end ? DONE : !is_dly ? WRITE : tbl_data[7:0] == 8'd0 ? NEXT : DELAY;
      WRITE:           nxt = !wr_fin ? WRITE : !iic_nack ? WR_OK : retry == MAX_R ? ERR : WRITE;
      DELAY:           nxt = ms_end ? NEXT : DELAY;
      NEXT:            nxt = last ? DONE : FETCH;
`ifdef OV_SEQ_READBACK_EN
      READ:            nxt = !rd_fin ? READ : rd_ok ? NEXT : retry == MAX_R ? ERR : WRITE;
`endif
      default:         nxt = IDLE;
    endcase
  end
  // datapath: request handshake, retry count, delay timers, table pointer and status
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      tbl_addr <= '0;
      wr_req   <= 1'b0;
      wr_reg   <= '0;
      wr_dat   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      retry    <= '0;
      us_cnt   <= '0;
      ms_cnt   <= '0;
`ifdef OV_SEQ_READBACK_EN
      rd_req   <= 1'b0;
      mismatch <= 1'b0;
`endif
    end else begin
      busy <= !(nxt inside {IDLE, DONE, ERR});
      done <= nxt == DONE;
      err  <= nxt == ERR;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          tbl_addr <= '0;
          retry    <= '0;
`ifdef OV_SEQ_READBACK_EN
          mismatch <= 1'b0;
`endif
        end
        DECODE: begin
          if (!is_end && !is_dly) begin
            wr_req <= 1'b1;
            wr_reg <= tbl_data[15:8];
            wr_dat <= tbl_data[7:0];
          end
          ms_cnt <= tbl_data[7:0];
          us_cnt <= '0;
        end
        WRITE: if (!wr_req) wr_req <= 1'b1;
        else if (iic_done) begin
          wr_req <= 1'b0;
          if (!iic_nack) begin
`ifdef OV_SEQ_READBACK_EN
            rd_req <= 1'b1;
`else
            retry <= '0;
`endif
          end else if (retry == MAX_R) begin
            err_idx <= tbl_addr;
`ifdef OV_SEQ_READBACK_EN
            mismatch <= 1'b0;
`endif
          end else retry <= retry + 4'd1;
        end
        DELAY: if (pluse_us) begin
          us_cnt <= us_cnt == US_TOP ? '0 : us_cnt + 10'd1;
          if (us_cnt == US_TOP) ms_cnt <= ms_cnt - 8'd1;
        end
        NEXT: if (!last) tbl_addr <= tbl_addr + TBL_AW'(1);
`ifdef OV_SEQ_READBACK_EN
        READ: if (iic_done) begin
          rd_req <= 1'b0;
          if (rd_ok) retry <= '0;
          else if (retry == MAX_R) begin
            err_idx  <= tbl_addr;
            mismatch <= !iic_nack;
          end else retry <= retry + 4'd1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ov_reg_seq.sv
// tb_ov_reg_seq: randomized self-checking bench for ov_reg_seq against a table-walk reference model
module tb_ov_reg_seq;
  localparam int AW = 8, DEPTH = 256, MAXR = 3;
  logic clk_sys = 0, rst = 1, pluse_us = 1, start = 0, iic_done = 0, iic_nack = 0;
  logic [AW-1:0] tbl_addr, err_idx;
  logic [15:0] tbl_data;
  logic wr_req, busy, done, err;
  logic [7:0] wr_dev, wr_reg, wr_dat;
  int nchk = 0, nerr = 0;
  logic [15:0] mem [DEPTH];
  bit nack_plan[$], nack_q[$];
  logic [15:0] log_q[$], exp_log[$];
  bit exp_err;
  int exp_idx, exp_addr;
  int lat = 2, cyc = 0, rises = 0, low_run = 0, stab_err = 0, cnt = 0;
  int gap_q[$], rise_cyc[$];
  bit pend = 0;
  logic prev_req = 0;
  logic [15:0] cur;

  ov_reg_seq #(.DEV_ID(8'h42), .TBL_AW(AW), .MAX_RETRY(MAXR), .US_PER_MS(1000)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .wr_req(wr_req), .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_dat(wr_dat),
    .iic_done(iic_done), .iic_nack(iic_nack),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) tbl_data <= mem[tbl_addr];

  // IIC master stand-in: answers each request after lat cycles, NACKing per nack_q
  initial forever begin
    @(posedge clk_sys); #1;
    iic_done = 0;
    iic_nack = 0;
    if (rst) pend = 0;
    else if (pend) begin
      if (!wr_req || {wr_reg, wr_dat} != cur) stab_err++;
      if (cnt == 0) begin
        iic_done = 1;
        iic_nack = nack_q.size() > 0 ? nack_q.pop_front() : 1'b0;
        pend = 0;
      end else cnt--;
    end else if (wr_req) begin
      pend = 1;
      cnt = lat;
      cur = {wr_reg, wr_dat};
      log_q.push_back(cur);
    end
  end

  // request edge monitor: counts assertions and low gaps between them
  initial forever begin
    @(posedge clk_sys); #1;
    cyc++;
    if (wr_req && !prev_req) begin
      rises++;
      rise_cyc.push_back(cyc);
      if (low_run > 0) gap_q.push_back(low_run);
      low_run = 0;
    end else if (!wr_req && (prev_req || low_run > 0)) low_run++;
    prev_req = wr_req;
  end

  // reference: walk the table by its rules, one transaction per attempt
  function automatic void model_run();
    int k = 0;
    bit nk;
    exp_log = {};
    exp_err = 0;
    exp_idx = 0;
    exp_addr = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] == 16'hFFFF) begin exp_addr = i; return; end
      if (mem[i][15:8] == 8'hFF) continue;
      for (int a = 0; a <= MAXR; a++) begin
        nk = k < nack_plan.size() ? nack_plan[k] : 1'b0;
        k++;
        exp_log.push_back(mem[i]);
        if (!nk) break;
        if (a == MAXR) begin exp_err = 1; exp_idx = i; exp_addr = i; return; end
      end
    end
  endfunction

  function automatic int log_diff();
    if (log_q.size() != exp_log.size()) return -2;
    foreach (exp_log[i]) if (log_q[i] !== exp_log[i]) return i;
    return -1;
  endfunction

  task automatic setup(input int l);
    @(negedge clk_sys);
    lat = l;
    log_q = {};
    nack_q = nack_plan;
    rises = 0;
    low_run = 0;
    gap_q = {};
    rise_cyc = {};
    stab_err = 0;
    model_run();
  endtask

  task automatic pulse_start();
    @(posedge clk_sys); #1 start = 1;
    @(posedge clk_sys); #1 start = 0;
  endtask

  task automatic wait_end(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(posedge clk_sys); #2;
      ok = done || err;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hFFFF;
    rst = 1;
    repeat (3) @(posedge clk_sys);
    #2;
    nchk++; if ({tbl_addr, err_idx} !== '0) begin nerr++; $display("FAIL reset_addr: tbl_addr=%h err_idx=%h want 0", tbl_addr, err_idx); end
    nchk++; if ({wr_req, wr_reg, wr_dat} !== '0) begin nerr++; $display("FAIL reset_wr: req=%b reg=%h dat=%h want 0", wr_req, wr_reg, wr_dat); end
    nchk++; if ({busy, done, err} !== 3'b000) begin nerr++; $display("FAIL reset_status: busy/done/err=%b want 000", {busy, done, err}); end
    nchk++; if (wr_dev !== 8'h42) begin nerr++; $display("FAIL reset_dev: wr_dev=%h want 42", wr_dev); end
    @(posedge clk_sys); #1 rst = 0;
  endtask

  task automatic test_basic;
    bit ok;
    int d;
    mem[0] = 16'h1280; mem[1] = 16'h1100; mem[2] = 16'hFFFF;
    nack_plan = {};
    setup(20);
    pulse_start();
    #1;
    nchk++; if (busy !== 1'b1 || tbl_addr !== '0) begin nerr++; $display("FAIL basic_start: busy=%b tbl_addr=%h want 1/00", busy, tbl_addr); end
    wait_end(1000, ok);
    nchk++; if (!ok) begin nerr++; $display("FAIL basic_timeout: no done/err within 1000 cycles"); end
    d = log_diff();
    nchk++; if (d != -1 || exp_log.size() != 2) begin nerr++; $display("FAIL basic_log: writes=%0d diff_at=%0d want %0d", log_q.size(), d, exp_log.size()); end
    nchk++; if ({done, err, busy} !== 3'b100) begin nerr++; $display("FAIL basic_status: done/err/busy=%b want 100", {done, err, busy}); end
    nchk++; if (stab_err != 0) begin nerr++; $display("FAIL basic_stable: unstable_cycles=%0d want 0", stab_err); end
  endtask

  task automatic test_delay;
    bit ok;
    int t0, dt;
    mem[0] = 16'hFF05; mem[1] = 16'h3A04; mem[2] = 16'hFFFF;
    nack_plan = {};
    setup(2);
    pulse_start();
    #1 t0 = cyc;
    wait_end(8000, ok);
    nchk++; if (!ok) begin nerr++; $display("FAIL delay_timeout: no done/err within 8000 cycles"); end
    dt = rise_cyc.size() > 0 ? rise_cyc[0] - t0 : -1;
    nchk++; if (rise_cyc.size() != 1 || dt < 5002 || dt > 5008) begin nerr++; $display("FAIL delay_time: rises=%0d delta=%0d want 1 rise at 5002..5008", rise_cyc.size(), dt); end
    nchk++; if (log_diff() != -1) begin nerr++; $display("FAIL delay_log: writes=%0d want %0d", log_q.size(), exp_log.size()); end
    nchk++; if ({done, err} !== 2'b10) begin nerr++; $display("FAIL delay_status: done/err=%b want 10", {done, err}); end
  endtask

  task automatic test_retry_err;
    bit ok;
    mem[0] = 16'h1280; mem[1] = 16'hFFFF;
    nack_plan = {1, 1, 1, 1, 1, 1};
    setup(3);
    pulse_start();
    wait_end(500, ok);
    nchk++; if (!ok) begin nerr++; $display("FAIL retry_err_timeout: no done/err within 500 cycles"); end
    nchk++; if (rises != 4) begin nerr++; $display("FAIL retry_err_count: requests=%0d want 4", rises); end
    nchk++; if (gap_q.size() != 3 || gap_q.sum() != 3) begin nerr++; $display("FAIL retry_err_gap: gaps=%0d total=%0d want 3 gaps of 1", gap_q.size(), gap_q.sum()); end
    nchk++; if ({err, done, busy} !== 3'b100 || err_idx !== '0) begin nerr++; $display("FAIL retry_err_status: err/done/busy=%b err_idx=%h want 100/00", {err, done, busy}, err_idx); end
    nchk++; if (log_diff() != -1 || !exp_err) begin nerr++; $display("FAIL retry_err_log: writes=%0d want %0d", log_q.size(), exp_log.size()); end
  endtask

  task automatic test_retry_ok;
    bit ok;
    mem[0] = 16'h1280; mem[1] = 16'h1100; mem[2] = 16'hFFFF;
    nack_plan = {1, 1};
    setup(4);
    pulse_start();
    wait_end(500, ok);
    nchk++; if (!ok) begin nerr++; $display("FAIL retry_ok_timeout: no done/err within 500 cycles"); end
    nchk++; if (rises != 4 || gap_q.size() < 2 || gap_q[0] != 1 || gap_q[1] != 1) begin nerr++; $display("FAIL retry_ok_count: requests=%0d gaps=%0d want 4 with 1-cycle retry gaps", rises, gap_q.size()); end
    nchk++; if ({done, err} !== 2'b10) begin nerr++; $display("FAIL retry_ok_status: done/err=%b want 10", {done, err}); end
    nchk++; if (log_diff() != -1) begin nerr++; $display("FAIL retry_ok_log: writes=%0d want %0d", log_q.size(), exp_log.size()); end
  endtask

  task automatic test_full_table;
    bit ok;
    for (int i = 0; i < DEPTH; i++) mem[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
    nack_plan = {};
    setup(1);
    pulse_start();
    wait_end(20000, ok);
    nchk++; if (!ok) begin nerr++; $display("FAIL full_timeout: no done/err within 20000 cycles"); end
    nchk++; if ({done, err} !== 2'b10 || tbl_addr !== 8'hFF) begin nerr++; $display("FAIL full_end: done/err=%b tbl_addr=%h want 10/ff", {done, err}, tbl_addr); end
    nchk++; if (log_diff() != -1 || log_q.size() != DEPTH) begin nerr++; $display("FAIL full_log: writes=%0d want %0d", log_q.size(), DEPTH); end
    repeat (5) @(posedge clk_sys);
    #2;
    nchk++; if (tbl_addr !== 8'hFF || done !== 1'b1) begin nerr++; $display("FAIL full_hold: tbl_addr=%h done=%b want ff/1", tbl_addr, done); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    mem[0] = 16'h1280; mem[1] = 16'h1100; mem[2] = 16'hFFFF;
    nack_plan = {};
    setup(30);
    pulse_start();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk_sys); #2; ok = wr_req; end
    nchk++; if (!ok) begin nerr++; $display("FAIL mid_req: wr_req not seen within 20 cycles"); end
    repeat (4) @(posedge clk_sys);
    #1 rst = 1;
    @(posedge clk_sys); #2;
    nchk++; if ({wr_req, busy} !== 2'b00 || tbl_addr !== '0) begin nerr++; $display("FAIL mid_rst: wr_req/busy=%b tbl_addr=%h want 00/00", {wr_req, busy}, tbl_addr); end
    @(posedge clk_sys); #1 rst = 0;
    setup(5);
    pulse_start();
    #1;
    nchk++; if (busy !== 1'b1 || tbl_addr !== '0) begin nerr++; $display("FAIL mid_restart: busy=%b tbl_addr=%h want 1/00", busy, tbl_addr); end
    repeat (6) @(posedge clk_sys);
    pulse_start();
    repeat (9) @(posedge clk_sys);
    pulse_start();
    wait_end(500, ok);
    nchk++; if (!ok) begin nerr++; $display("FAIL mid_timeout: no done/err within 500 cycles"); end
    nchk++; if (log_diff() != -1 || {done, err} !== 2'b10) begin nerr++; $display("FAIL mid_log: writes=%0d done/err=%b want %0d/10", log_q.size(), {done, err}, exp_log.size()); end
  endtask

  task automatic test_random;
    bit ok;
    int n, r, d;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 15);
        mem[i] = r == 0 ? 16'hFF00 : r == 1 ? 16'hFF01 : {8'($urandom_range(0, 254)), 8'($urandom)};
      end
      mem[n] = 16'hFFFF;
      nack_plan = {};
      for (int i = 0; i < 40; i++) nack_plan.push_back($urandom_range(0, 2) == 0);
      setup($urandom_range(0, 6));
      pulse_start();
      wait_end(5000, ok);
      nchk++; if (!ok) begin nerr++; $display("FAIL rand%0d_timeout: no done/err within 5000 cycles", it); end
      d = log_diff();
      nchk++; if (d != -1) begin nerr++; $display("FAIL rand%0d_log: writes=%0d diff_at=%0d want %0d", it, log_q.size(), d, exp_log.size()); end
      nchk++; if ({done, err, busy, err_idx, tbl_addr} !== {!exp_err, exp_err, 1'b0, 8'(exp_idx), 8'(exp_addr)}) begin
        nerr++; $display("FAIL rand%0d_status: done/err/busy=%b err_idx=%h tbl_addr=%h want %b/%h/%h", it, {done, err, busy}, err_idx, tbl_addr, {!exp_err, exp_err, 1'b0}, 8'(exp_idx), 8'(exp_addr));
      end
      nchk++; if (stab_err != 0) begin nerr++; $display("FAIL rand%0d_stable: unstable_cycles=%0d want 0", it, stab_err); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_delay;
    test_retry_err;
    test_retry_ok;
    test_full_table;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
